io_memory: RTL and testbench
============================

Name: io_memory

Overview:
- Memory-mapped I/O register block for the single-cycle processor's data path.
- Holds the output registers that drive the board LEDs and four seven-segment displays, and returns switch or key state on the read port.
- The address decoder outside this block converts the CPU address into the one-hot strobes isHex, isLedr, isLedg and isSwitches, so the block never sees an address.

Parameters:
- DBITS, 32: data bus width of dataIn and ioOut; must be >= 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- isHex  input  1  write strobe for the HEX display register.
- isLedr  input  1  write strobe for the red-LED register.
- isLedg  input  1  write strobe for the green-LED register.
- isSwitches  input  1  read select: 1 = switches, 0 = keys.
- switches  input  10  slide switch levels.
- keys  input  4  push-button levels, used raw with no inversion.
- dataIn  input  DBITS  CPU store data.
- ledr  output  10  red LEDs.
- ledg  output  8  green LEDs.
- hex0  output  7  digit 0 (least significant), active-low segments.
- hex1  output  7  digit 1, active-low segments.
- hex2  output  7  digit 2, active-low segments.
- hex3  output  7  digit 3, active-low segments.
- ioOut  output  DBITS  load data returned to the CPU.

Behaviour:
- Reset (resetN=0, asynchronous): hexReg[15:0]=0, ledr=0, ledg=0, ioOut=0.
  - While reset is held, all four digits therefore display "0" (7'b1000000).
- Rising clk with isHex=1: hexReg <= dataIn[15:0]. dataIn[DBITS-1:16] is ignored.
- Rising clk with isLedr=1: ledr <= dataIn[9:0].
- Rising clk with isLedg=1: ledg <= dataIn[7:0].
- An unselected register holds its value.
- Strobes are independent. If several are high in the same cycle, every selected register is written from the same dataIn.
- Write latency is one edge: outputs reflect the new value right after the rising edge.
- Read path is registered and updates on every rising edge:
  - isSwitches=1: ioOut <= zero-extended switches.
  - isSwitches=0: ioOut <= zero-extended keys.
  - Read latency is one edge. The read is independent of the write strobes, so a simultaneous write and read are both performed.
- Display decode is combinational from hexReg:
  - hex0 = seg(hexReg[3:0]), hex1 = seg([7:4]), hex2 = seg([11:8]), hex3 = seg([15:12]).
  - Segment bit 0 = segment a through bit 6 = segment g; 0 = segment lit.
- seg() truth table (nibble value: pattern, bit 6 down to bit 0):
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
  - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
  - 8: 0000000, 9: 0010000, A: 0001000, b: 0000011
  - C: 1000110, d: 0100001, E: 0000110, F: 0001110
- Reset asserted mid-operation clears everything immediately, regardless of clk. Normal operation resumes on the first rising edge after resetN returns to 1.

Optional Feature:
- Macro: IO_INPUT_SYNC_EN.
- When defined:
  - switches and keys each pass through a 2-flop synchronizer (reset value 0) before the read mux.
  - Read latency from a pin change to ioOut becomes 3 rising edges.
  - The isSwitches select still takes effect after 1 edge.
- When undefined: the pins feed the read mux directly, giving a 1-edge latency.

Test Plan:
- Reset -> ledr=0, ledg=0, ioOut=0, hex3..hex0 all 1000000.
- isHex=1, dataIn=F0FBFAFD, one edge -> hex3=0001110 (F), hex2=0001000 (A), hex1=0001110 (F), hex0=0100001 (d); ledr and ledg unchanged.
- isSwitches=1, switches=10'b1010101010, isHex=0, dataIn=F8F8F8F8, one edge -> ioOut=0x000002AA; HEX digits unchanged.
- isSwitches=0, keys=4'b0101 -> ioOut=0x00000005 (after 3 edges when IO_INPUT_SYNC_EN is defined).
- isLedr=1, dataIn=FF77FF77 -> ledr=10'b1101110111. Then isLedg=1, dataIn=FF0FFF0F -> ledg=8'b00001111 and ledr holds.
- isHex=1, dataIn=01020304 -> hex3=1000000, hex2=0110000, hex1=1000000, hex0=0011001.
- Assert resetN=0 between edges -> all outputs cleared without a clock edge.

Source files
------------

// File: rtl/io_memory.sv
// io_memory: memory-mapped LED / seven-segment output registers and switch/key read port
//
// Ports:
//   clk         system clock, rising edge
//   resetN      asynchronous active-low reset
//   isHex       write strobe, hexReg <= dataIn[15:0]
//   isLedr      write strobe, ledr <= dataIn[9:0]
//   isLedg      write strobe, ledg <= dataIn[7:0]
//   isSwitches  read select, 1 = switches, 0 = keys
//   switches    slide switch levels
//   keys        push-button levels, raw
//   dataIn      CPU store data
//   ledr, ledg  LED registers
//   hex0..hex3  active-low segment patterns of hexReg nibbles 0..3
//   ioOut       registered load data, zero-extended
//
// Optional feature: define IO_INPUT_SYNC_EN to pass switches and keys through
// a 2-flop synchronizer, making pin-to-ioOut latency 3 edges.
module io_memory #(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             isHex,
    input  logic             isLedr,
    input  logic             isLedg,
    input  logic             isSwitches,
    input  logic [9:0]       switches,
    input  logic [3:0]       keys,
    input  logic [DBITS-1:0] dataIn,
    output logic [9:0]       ledr,
    output logic [7:0]       ledg,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [DBITS-1:0] ioOut
);
    logic [15:0]      hex_q;
    logic [9:0]       ledr_q;
    logic [7:0]       ledg_q;
    logic [DBITS-1:0] io_q, io_d;
    logic [9:0]       sw_rd;
    logic [3:0]       key_rd;

`ifdef IO_INPUT_SYNC_EN
    logic [9:0] sw_s1_q, sw_s2_q;
    logic [3:0] key_s1_q, key_s2_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= '0;
            key_s2_q <= '0;
        end else begin
            sw_s1_q  <= switches;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= keys;
            key_s2_q <= key_s1_q;
        end
    end

    assign sw_rd  = sw_s2_q;
    assign key_rd = key_s2_q;
`else
    assign sw_rd  = switches;
    assign key_rd = keys;
`endif

    assign io_d = isSwitches ? {{(DBITS-10){1'b0}}, sw_rd} : {{(DBITS-4){1'b0}}, key_rd};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hex_q  <= '0;
            ledr_q <= '0;
            ledg_q <= '0;
            io_q   <= '0;
        end else begin
            if (isHex)  hex_q  <= dataIn[15:0];
            if (isLedr) ledr_q <= dataIn[9:0];
            if (isLedg) ledg_q <= dataIn[7:0];
            io_q <= io_d;
        end
    end

    // Segment bit 0 = a .. bit 6 = g, 0 lights the segment.
    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    assign hex0  = seg(hex_q[3:0]);
    assign hex1  = seg(hex_q[7:4]);
    assign hex2  = seg(hex_q[11:8]);
    assign hex3  = seg(hex_q[15:12]);
    assign ledr  = ledr_q;
    assign ledg  = ledg_q;
    assign ioOut = io_q;
endmodule

// File: tb/tb_io_memory.sv
// tb_io_memory: randomized self-checking bench for io_memory against a behavioural model
module tb_io_memory;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        isHex = 1'b0, isLedr = 1'b0, isLedg = 1'b0, isSwitches = 1'b0;
    logic [9:0]  switches = '0;
    logic [3:0]  keys = '0;
    logic [31:0] dataIn = '0;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic [31:0] ioOut;

    io_memory #(.DBITS(32)) dut (
        .clk(clk), .resetN(resetN), .isHex(isHex), .isLedr(isLedr), .isLedg(isLedg),
        .isSwitches(isSwitches), .switches(switches), .keys(keys), .dataIn(dataIn),
        .ledr(ledr), .ledg(ledg), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .ioOut(ioOut)
    );

    always #5 clk = ~clk;

`ifdef IO_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [6:0]  seg_tab [16];
    logic [15:0] m_hex;
    logic [9:0]  m_ledr, sw_h1, sw_h2;
    logic [7:0]  m_ledg;
    logic [3:0]  k_h1, k_h2;
    logic [31:0] m_io;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hex = '0; m_ledr = '0; m_ledg = '0; m_io = '0;
        sw_h1 = '0; sw_h2 = '0; k_h1 = '0; k_h2 = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ledr"}, {22'd0, ledr}, {22'd0, m_ledr});
        chk({tag, ".ledg"}, {24'd0, ledg}, {24'd0, m_ledg});
        chk({tag, ".io"}, ioOut, m_io);
        chk({tag, ".hex"}, {4'd0, hex3, hex2, hex1, hex0},
            {4'd0, seg_tab[m_hex[15:12]], seg_tab[m_hex[11:8]], seg_tab[m_hex[7:4]], seg_tab[m_hex[3:0]]});
    endtask

    task automatic step(input logic hx, input logic lr, input logic lg, input logic sel,
                        input logic [31:0] d, input logic [9:0] sw, input logic [3:0] k);
        isHex = hx; isLedr = lr; isLedg = lg; isSwitches = sel;
        dataIn = d; switches = sw; keys = k;
        @(posedge clk);
        if (hx) m_hex = d[15:0];
        if (lr) m_ledr = d[9:0];
        if (lg) m_ledg = d[7:0];
`ifdef IO_INPUT_SYNC_EN
        m_io = sel ? {22'd0, sw_h2} : {28'd0, k_h2};
        sw_h2 = sw_h1; sw_h1 = sw;
        k_h2 = k_h1; k_h1 = k;
`else
        m_io = sel ? {22'd0, sw} : {28'd0, k};
`endif
        #1;
        check_all("step");
    endtask

    task automatic rand_step();
        step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             1'($urandom), $urandom, 10'($urandom), 4'($urandom));
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_reset();
        #12;
        check_all("reset");
        chk("reset_hex", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, {4{7'b1000000}}});
        @(negedge clk);
        resetN = 1'b1;

        step(1, 0, 0, 0, 32'hF0FBFAFD, 10'd0, 4'd0);
        chk("hex_FAFD", {4'd0, hex3, hex2, hex1, hex0},
            {4'd0, 7'b0001110, 7'b0001000, 7'b0001110, 7'b0100001});
        chk("leds_idle", {14'd0, ledr, ledg}, 32'd0);

        repeat (LAT) step(0, 0, 0, 1, 32'hF8F8F8F8, 10'b1010101010, 4'd0);
        chk("sw_read", ioOut, 32'h000002AA);
        chk("hex_hold", {4'd0, hex3, hex2, hex1, hex0},
            {4'd0, 7'b0001110, 7'b0001000, 7'b0001110, 7'b0100001});

        repeat (LAT) step(0, 0, 0, 0, 32'h0, 10'b1010101010, 4'b0101);
        chk("key_read", ioOut, 32'h00000005);

        step(0, 1, 0, 0, 32'hFF77FF77, 10'd0, 4'd0);
        chk("ledr_wr", {22'd0, ledr}, {22'd0, 10'b1101110111});
        step(0, 0, 1, 0, 32'hFF0FFF0F, 10'd0, 4'd0);
        chk("ledg_wr", {24'd0, ledg}, 32'h0000000F);
        chk("ledr_hold", {22'd0, ledr}, {22'd0, 10'b1101110111});

        step(1, 0, 0, 0, 32'h01020304, 10'd0, 4'd0);
        chk("hex_0304", {4'd0, hex3, hex2, hex1, hex0},
            {4'd0, 7'b1000000, 7'b0110000, 7'b1000000, 7'b0011001});

        step(1, 1, 1, 1, 32'hDEADBEEF, 10'h3FF, 4'hF);
        repeat (300) rand_step();

        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_hex", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, {4{7'b1000000}}});
        @(negedge clk);
        resetN = 1'b1;
        repeat (50) rand_step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
